// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : aes_pkg
//  Description : Shared AES block constants, packer state encoding and the
//                PKCS#7 pad-byte helper.
//  Revision    : 1.0  initial release
// ============================================================================
package aes_pkg;

    localparam int AES_BLOCK_BYTES = 16;

    // Packer FSM: LO awaits the first half, HI the second half, PAD emits
    // the extra all-pad block after a block-aligned message end.
    typedef enum logic [1:0] {
        LO  = 2'd0,
        HI  = 2'd1,
        PAD = 2'd2
    } packer_state_t;

    // Pad byte for a block holding valid_bytes message bytes (0..16).
    // A full block yields 0, an empty block yields 16 (0x10).
    function automatic logic [7:0] pad_byte(input logic [4:0] valid_bytes);
        logic [5:0] n;
        n = 6'(AES_BLOCK_BYTES) - {1'b0, valid_bytes};
        return {2'b00, n};
    endfunction

endpackage
`default_nettype wire

// File: rtl/axis_keep_count.sv
`default_nettype none
// ============================================================================
//  Module      : axis_keep_count
//  Description : Combinational 8-bit tkeep to byte count (0..8) plus a flag
//                that is set when the enables are contiguous from bit 0.
//  Revision    : 1.0  initial release
// ============================================================================
module axis_keep_count (
    input  logic [7:0] i_keep,
    output logic [3:0] o_count,
    output logic       o_contig
);

    // Population count of the byte enables.
    always_comb begin
        o_count = 4'd0;
        for (int i = 0; i < 8; i++) begin
            o_count = o_count + {3'b000, i_keep[i]};
        end
    end

    // A run of ones from bit 0 is of the form 2^k-1, so keep & (keep+1) is 0.
    // An all-zero keep also passes here; it is flagged separately.
    assign o_contig = ((i_keep & (i_keep + 8'd1)) == 8'd0);

endmodule
`default_nettype wire

// File: rtl/axis_block_packer.sv
`default_nettype none
// ============================================================================
//  Module      : axis_block_packer
//  Description : Packs a 64-bit AXI-Stream into 128-bit AES blocks, one output
//                beat per block. The partial final block is zero-filled with
//                exact tkeep, or PKCS#7 padded with full tkeep (and an extra
//                all-pad block for block-aligned messages) when the macro
//                AES_PKCS7_PAD_EN is defined.
//  Revision    : 1.0  initial release
// ============================================================================
module axis_block_packer
    import aes_pkg::*;
#(
    parameter int TDATA_WIDTH = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       s_tvalid,
    output logic                       s_tready,
    input  logic [TDATA_WIDTH-1:0]     s_tdata,
    input  logic [TDATA_WIDTH/8-1:0]   s_tkeep,
    input  logic                       s_tlast,
    input  logic                       s_tuser,
    output logic                       m_tvalid,
    input  logic                       m_tready,
    output logic [2*TDATA_WIDTH-1:0]   m_tdata,
    output logic [TDATA_WIDTH/4-1:0]   m_tkeep,
    output logic                       m_tlast,
    output logic                       m_tuser,
    output logic                       err
);

    localparam int         c_beat_bytes = TDATA_WIDTH / 8;
    localparam int         c_blk_bytes  = 2 * c_beat_bytes;
    localparam logic [7:0] c_full_pad   = 8'(AES_BLOCK_BYTES);

    packer_state_t                r_state;
    logic [TDATA_WIDTH-1:0]       r_lo_data;
    logic [c_beat_bytes-1:0]      r_lo_keep;
    logic [3:0]                   r_lo_count;
    logic                         r_lo_user;

    logic                         r_m_tvalid;
    logic [2*TDATA_WIDTH-1:0]     r_m_tdata;
    logic [c_blk_bytes-1:0]       r_m_tkeep;
    logic                         r_m_tlast;
    logic                         r_m_tuser;
    logic                         r_err;

    logic [3:0]                   w_count;
    logic                         w_contig;
    logic                         w_out_free;
    logic                         w_accept;
    logic                         w_complete;
    logic                         w_pad_next;
    logic                         w_beat_err;
    logic [4:0]                   w_total;
    logic [7:0]                   w_fill_byte;
    logic [2*TDATA_WIDTH-1:0]     w_blk_data;
    logic [c_blk_bytes-1:0]       w_blk_keep;
    logic [2*TDATA_WIDTH-1:0]     w_fill_data;
    logic [c_blk_bytes-1:0]       w_out_keep;

    axis_keep_count u_keep_count (
        .i_keep   (s_tkeep),
        .o_count  (w_count),
        .o_contig (w_contig)
    );

    // Output slot is free when empty or being drained this cycle.
    assign w_out_free = !r_m_tvalid || m_tready;
    assign s_tready   = ((r_state == LO) || (r_state == HI)) && w_out_free;
    assign w_accept   = s_tvalid && s_tready;
    assign w_complete = w_accept && ((r_state == HI) || s_tlast);

    // Valid bytes in the block being completed.
    assign w_total = (r_state == HI) ? (5'(r_lo_count) + 5'(w_count)) : 5'(w_count);

    // Block assembled from the held first half (if any) and the current beat.
    assign w_blk_data = (r_state == HI) ? {s_tdata, r_lo_data}
                                        : {{TDATA_WIDTH{1'b0}}, s_tdata};
    assign w_blk_keep = (r_state == HI) ? {s_tkeep, r_lo_keep}
                                        : {{c_beat_bytes{1'b0}}, s_tkeep};

`ifdef AES_PKCS7_PAD_EN
    assign w_fill_byte = pad_byte(w_total);
    assign w_out_keep  = {c_blk_bytes{1'b1}};
    // A block-aligned message end needs a whole extra pad block.
    assign w_pad_next  = (r_state == HI) && s_tlast && (w_total == 5'(c_blk_bytes));
`else
    assign w_fill_byte = 8'h00;
    assign w_out_keep  = w_blk_keep;
    assign w_pad_next  = 1'b0;
`endif

    // Every disabled byte position carries the fill byte.
    for (genvar i = 0; i < c_blk_bytes; i++) begin : g_fill
        assign w_fill_data[8*i +: 8] = w_blk_keep[i] ? w_blk_data[8*i +: 8] : w_fill_byte;
    end

    assign w_beat_err = !w_contig
                     || (s_tkeep == '0)
                     || (!s_tlast && (s_tkeep != {c_beat_bytes{1'b1}}))
                     || ((r_state == HI) && (s_tuser != r_lo_user));

    // Packer FSM with registered output slot and sticky error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= LO;
            r_lo_data  <= '0;
            r_lo_keep  <= '0;
            r_lo_count <= 4'd0;
            r_lo_user  <= 1'b0;
            r_m_tvalid <= 1'b0;
            r_m_tdata  <= '0;
            r_m_tkeep  <= '0;
            r_m_tlast  <= 1'b0;
            r_m_tuser  <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            if (w_accept && w_beat_err) begin
                r_err <= 1'b1;
            end

            case (r_state)
                LO: begin
                    if (w_accept && !s_tlast) begin
                        r_lo_data  <= s_tdata;
                        r_lo_keep  <= s_tkeep;
                        r_lo_count <= w_count;
                        r_lo_user  <= s_tuser;
                        r_state    <= HI;
                    end
                end
                HI: begin
                    if (w_accept) begin
                        r_state <= w_pad_next ? PAD : LO;
                    end
                end
`ifdef AES_PKCS7_PAD_EN
                PAD: begin
                    if (w_out_free) begin
                        r_state <= LO;
                    end
                end
`endif
                default: r_state <= LO;
            endcase

            if (w_complete) begin
                r_m_tvalid <= 1'b1;
                r_m_tdata  <= w_fill_data;
                r_m_tkeep  <= w_out_keep;
                r_m_tlast  <= s_tlast && !w_pad_next;
                r_m_tuser  <= (r_state == HI) ? r_lo_user : s_tuser;
`ifdef AES_PKCS7_PAD_EN
            end else if ((r_state == PAD) && w_out_free) begin
                r_m_tvalid <= 1'b1;
                r_m_tdata  <= {c_blk_bytes{c_full_pad}};
                r_m_tkeep  <= {c_blk_bytes{1'b1}};
                r_m_tlast  <= 1'b1;
                r_m_tuser  <= r_lo_user;
`endif
            end else if (m_tready) begin
                r_m_tvalid <= 1'b0;
            end
        end
    end

    assign m_tvalid = r_m_tvalid;
    assign m_tdata  = r_m_tdata;
    assign m_tkeep  = r_m_tkeep;
    assign m_tlast  = r_m_tlast;
    assign m_tuser  = r_m_tuser;
    assign err      = r_err;

endmodule
`default_nettype wire
